// File: rtl/hardcaml_lib_divmod.sv
// Iterative radix-2 restoring divider: quotient/remainder for signed or unsigned b-bit operands.
// Optional macro HARDCAML_LIB_DIVMOD_EARLY_OUT_EN: divide-by-zero bypasses the iterations (latency 1).
module hardcaml_lib_divmod #(
    parameter int unsigned b = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         signed_op,
    input  logic [b-1:0] i0,
    input  logic [b-1:0] i1,
    output logic         busy,
    output logic         valid,
    output logic [b-1:0] quo,
    output logic [b-1:0] rem
);

    localparam int unsigned cw = $clog2(b + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t        state;
    logic [cw-1:0] cnt;
    logic [b-1:0]  dvd;     // dividend shifting out, quotient bits shifting in
    logic [b-1:0]  dvs;
    logic [b-1:0]  prem;
    logic          neg_q;
    logic          neg_r;
    logic          dz;

    logic [b-1:0]  abs0_c;
    logic [b-1:0]  abs1_c;
    logic [b:0]    shifted_c;
    logic [b:0]    diff_c;
    logic          ge_c;

    // Operand magnitudes and one restoring step on b+1-bit partial remainder
    always_comb begin
        abs0_c    = (signed_op && i0[b-1]) ? -i0 : i0;
        abs1_c    = (signed_op && i1[b-1]) ? -i1 : i1;
        shifted_c = {prem, dvd[b-1]};
        ge_c      = (shifted_c >= {1'b0, dvs});
        diff_c    = shifted_c - {1'b0, dvs};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            prem  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
            busy  <= 1'b0;
            valid <= 1'b0;
            quo   <= '0;
            rem   <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd   <= abs0_c;
                        dvs   <= abs1_c;
                        prem  <= '0;
                        neg_q <= signed_op & (i0[b-1] ^ i1[b-1]);
                        neg_r <= signed_op & i0[b-1];
                        dz    <= (i1 == '0);
                        cnt   <= cw'(b);
                        busy  <= 1'b1;
                        state <= CALC;
`ifdef HARDCAML_LIB_DIVMOD_EARLY_OUT_EN
                        // Pre-load |i0| as remainder so FIX restores the original dividend
                        if (i1 == '0) begin
                            prem  <= abs0_c;
                            state <= FIX;
                        end
`endif
                    end
                end
                CALC: begin
                    prem <= ge_c ? b'(diff_c) : b'(shifted_c);
                    dvd  <= {dvd[b-2:0], ge_c};
                    cnt  <= cnt - cw'(1);
                    if (cnt == cw'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // With a zero divisor every trial succeeds: quotient all ones, remainder |i0|
                    quo   <= dz ? '1 : (neg_q ? -dvd : dvd);
                    rem   <= neg_r ? -prem : prem;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hardcaml_lib_divmod.sv
// Directed self-checking bench for hardcaml_lib_divmod (b=32).
module tb_hardcaml_lib_divmod;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        busy;
    logic        valid;
    logic [31:0] quo;
    logic [31:0] rem;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef HARDCAML_LIB_DIVMOD_EARLY_OUT_EN
    localparam int dz_lat = 1;
`else
    localparam int dz_lat = 33;
`endif

    hardcaml_lib_divmod #(.b(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .signed_op(signed_op),
        .i0       (i0),
        .i1       (i1),
        .busy     (busy),
        .valid    (valid),
        .quo      (quo),
        .rem      (rem)
    );

    always #5 clock = ~clock;

    // Called at #1 after the accepting edge; returns edges until valid and busy-high samples
    task automatic wait_valid(output int lat, output int busy_cnt);
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
            if (valid) break;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic s,
                         output int lat, output int busy_cnt);
        @(negedge clock);
        i0 = a;
        i1 = d;
        signed_op = s;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        i0 = 32'hDEAD_BEEF;
        i1 = 32'h0;
        signed_op = ~s;
        wait_valid(lat, busy_cnt);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        signed_op = 1'b0;
        i0 = '0;
        i1 = '0;
        #3;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", valid); end
        n_checks++; if (quo !== 32'h0) begin n_fail++; $display("FAIL reset_quo got %h want 0", quo); end
        n_checks++; if (rem !== 32'h0) begin n_fail++; $display("FAIL reset_rem got %h want 0", rem); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_unsigned();
        int lat, bc;
        do_op(32'd100, 32'd7, 1'b0, lat, bc);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL udiv_latency got %0d want 33", lat); end
        n_checks++; if (bc !== 33) begin n_fail++; $display("FAIL udiv_busy_cycles got %0d want 33", bc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL udiv_busy_at_valid got %0b want 0", busy); end
        n_checks++; if (quo !== 32'd14) begin n_fail++; $display("FAIL udiv_quo got %0d want 14", quo); end
        n_checks++; if (rem !== 32'd2) begin n_fail++; $display("FAIL udiv_rem got %0d want 2", rem); end
        @(posedge clock);
        #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL udiv_valid_width got %0b want 0", valid); end
        n_checks++; if (quo !== 32'd14) begin n_fail++; $display("FAIL udiv_quo_hold got %0d want 14", quo); end
    endtask

    task automatic test_signed();
        int lat, bc;
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat, bc);
        n_checks++; if (quo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sdiv_m7_2_quo got %h want fffffffd", quo); end
        n_checks++; if (rem !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sdiv_m7_2_rem got %h want ffffffff", rem); end
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, lat, bc);
        n_checks++; if (quo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sdiv_7_m2_quo got %h want fffffffd", quo); end
        n_checks++; if (rem !== 32'd1) begin n_fail++; $display("FAIL sdiv_7_m2_rem got %h want 1", rem); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL sdiv_latency got %0d want 33", lat); end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        do_op(32'h1234, 32'd0, 1'b0, lat, bc);
        n_checks++; if (quo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL udz_quo got %h want ffffffff", quo); end
        n_checks++; if (rem !== 32'h1234) begin n_fail++; $display("FAIL udz_rem got %h want 1234", rem); end
        n_checks++; if (lat !== dz_lat) begin n_fail++; $display("FAIL udz_latency got %0d want %0d", lat, dz_lat); end
        n_checks++; if (bc !== dz_lat) begin n_fail++; $display("FAIL udz_busy_cycles got %0d want %0d", bc, dz_lat); end
        do_op(32'hFFFF_FFFB, 32'd0, 1'b1, lat, bc);
        n_checks++; if (quo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sdz_quo got %h want ffffffff", quo); end
        n_checks++; if (rem !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL sdz_rem got %h want fffffffb", rem); end
        n_checks++; if (lat !== dz_lat) begin n_fail++; $display("FAIL sdz_latency got %0d want %0d", lat, dz_lat); end
    endtask

    task automatic test_overflow();
        int lat, bc;
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bc);
        n_checks++; if (quo !== 32'h8000_0000) begin n_fail++; $display("FAIL sovf_quo got %h want 80000000", quo); end
        n_checks++; if (rem !== 32'h0) begin n_fail++; $display("FAIL sovf_rem got %h want 0", rem); end
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bc);
        n_checks++; if (quo !== 32'h0) begin n_fail++; $display("FAIL uovf_quo got %h want 0", quo); end
        n_checks++; if (rem !== 32'h8000_0000) begin n_fail++; $display("FAIL uovf_rem got %h want 80000000", rem); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        @(negedge clock);
        i0 = 32'd100;
        i1 = 32'd7;
        signed_op = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
            start = (lat == 9);
            i0 = 32'd50;
            i1 = 32'd5;
            if (valid) break;
        end
        start = 1'b0;
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL ignore_latency got %0d want 33", lat); end
        n_checks++; if (quo !== 32'd14) begin n_fail++; $display("FAIL ignore_quo got %0d want 14", quo); end
        n_checks++; if (rem !== 32'd2) begin n_fail++; $display("FAIL ignore_rem got %0d want 2", rem); end
        @(posedge clock);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_relaunch got busy %0b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        do_op(32'd100, 32'd7, 1'b0, lat, bc);
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid got %0b want 1", valid); end
        i0 = 32'd50;
        i1 = 32'd5;
        signed_op = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy got %0b want 1", busy); end
        wait_valid(lat, bc);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency got %0d want 33", lat); end
        n_checks++; if (quo !== 32'd10) begin n_fail++; $display("FAIL b2b_quo got %0d want 10", quo); end
        n_checks++; if (rem !== 32'd0) begin n_fail++; $display("FAIL b2b_rem got %0d want 0", rem); end
    endtask

    task automatic test_reset_mid();
        int lat, bc, pulses;
        @(negedge clock);
        i0 = 32'd1000;
        i1 = 32'd3;
        signed_op = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %0b want 0", busy); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %0b want 0", valid); end
        n_checks++; if (quo !== 32'h0) begin n_fail++; $display("FAIL midrst_quo got %h want 0", quo); end
        n_checks++; if (rem !== 32'h0) begin n_fail++; $display("FAIL midrst_rem got %h want 0", rem); end
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (valid) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_no_valid got %0d pulses want 0", pulses); end
        do_op(32'd100, 32'd7, 1'b0, lat, bc);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL postrst_latency got %0d want 33", lat); end
        n_checks++; if (quo !== 32'd14) begin n_fail++; $display("FAIL postrst_quo got %0d want 14", quo); end
        n_checks++; if (rem !== 32'd2) begin n_fail++; $display("FAIL postrst_rem got %0d want 2", rem); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
